// File: rtl/uart_rx_core.sv
// UART receive engine: 2-flop synchronizer, free-running sample-tick divider,
// majority-vote bit recovery and a single-entry holding register with pop handshake.
module uart_rx_core #(
  parameter int WIDTH       = 8,
  parameter int SAMPLE_RATE = 16,
  parameter int USE_PARITY  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_parity,
  input  logic [1:0]       cfg_stop_bits,
  input  logic [15:0]      cfg_clk_div,
  input  logic             uart_rx,
  input  logic             rx_req,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);
  localparam int SW = $clog2(SAMPLE_RATE);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SW-1:0] S_LO   = SW'(SAMPLE_RATE/2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(SAMPLE_RATE/2);
  localparam logic [SW-1:0] S_HI   = SW'(SAMPLE_RATE/2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [15:0]      div_cnt_q, div_cnt_d, div_max_q, div_max_d;
  logic             tick, vote, par_en, last_stop, ferr_now;
  state_t           state_q;
  logic [SW-1:0]    s_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] shift_q;
  logic             smp_a_q, smp_b_q, armed_q, perr_q, ferr_q, commit_q;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_ready_q, rx_ready_d, parity_err_q, parity_err_d;
  logic             frame_err_q, frame_err_d, overrun_q, overrun_d;

  always_comb begin
    rx_s1_d   = uart_rx;
    rx_s2_d   = rx_s1_q;
    tick      = (div_cnt_q == div_max_q);
    div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
    div_max_d = div_max_q;
    // New divisor is only picked up at a wrap so a tick period is never torn.
    if (tick) div_max_d = (cfg_clk_div == 16'd0) ? 16'd0 : cfg_clk_div - 16'd1;
    vote      = (smp_a_q & smp_b_q) | (smp_a_q & rx_s2_q) | (smp_b_q & rx_s2_q);
    par_en    = (USE_PARITY != 0) && (cfg_parity == 2'd1 || cfg_parity == 2'd2);
    last_stop = (cfg_stop_bits == 2'd0) || (bit_q != '0);
    ferr_now  = ferr_q | ~vote;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      div_cnt_q <= '0;
      div_max_q <= '0;
    end else begin
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      div_cnt_q <= div_cnt_d;
      div_max_q <= div_max_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      smp_a_q  <= 1'b0;
      smp_b_q  <= 1'b0;
      armed_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (state_q == IDLE) begin
        // Armed only after a high sample, so a held-low break never restarts.
        if (rx_s2_q) armed_q <= 1'b1;
        else if (armed_q) begin
          state_q <= START;
          armed_q <= 1'b0;
          s_q     <= '0;
          bit_q   <= '0;
          perr_q  <= 1'b0;
          ferr_q  <= 1'b0;
        end
      end else if (tick) begin
        s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
        if (s_q == S_LO)  smp_a_q <= rx_s2_q;
        if (s_q == S_MID) smp_b_q <= rx_s2_q;
        if (s_q == S_LAST) begin
          case (state_q)
            START: begin state_q <= DATA; bit_q <= '0; end
            DATA: begin
              bit_q <= (bit_q == B_LAST) ? '0 : bit_q + 1'b1;
              if (bit_q == B_LAST) state_q <= par_en ? PARITY : STOP;
            end
            PARITY:  begin state_q <= STOP; bit_q <= '0; end
            STOP:    bit_q <= 1'b1;
            default: state_q <= IDLE;
          endcase
        end
        // Vote block follows the bit-end block so its IDLE exits take priority.
        if (s_q == S_HI) begin
          case (state_q)
            START:  if (vote) state_q <= IDLE;
            DATA:   shift_q <= {vote, shift_q[WIDTH-1:1]};
            PARITY: perr_q <= ((^shift_q) ^ vote) != (cfg_parity == 2'd1);
            STOP: begin
              ferr_q <= ferr_now;
              if (last_stop) begin
                state_q  <= IDLE;
                commit_q <= 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_ready_d   = rx_ready_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (commit_q) begin
      if (!rx_ready_q || rx_req) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        rx_ready_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_req && rx_ready_q) begin
      rx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_ready_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_ready_q   <= rx_ready_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_ready   = rx_ready_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: drives serial frames and compares each
// received frame against a parity/stop-bit reference model.
`timescale 1ns/1ps
module tb_uart_rx_core;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  cfg_parity = 2'd0, cfg_stop_bits = 2'd0;
  logic [15:0] cfg_clk_div = 16'd54;
  logic        uart_rx = 1'b1, rx_req = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_ready, parity_err, frame_err, overrun;

  int     checks = 0, errors = 0;
  int     bit_clk = 864;
  int     rise_cnt = 0, ovr_cnt = 0;
  longint rise_t = 0, stop_t = 0;
  logic   rdy_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core #(.WIDTH(8), .SAMPLE_RATE(16), .USE_PARITY(1)) dut (
    .clk(clk), .rst(rst), .cfg_parity(cfg_parity), .cfg_stop_bits(cfg_stop_bits),
    .cfg_clk_div(cfg_clk_div), .uart_rx(uart_rx), .rx_req(rx_req), .rx_data(rx_data),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always @(negedge clk) begin
    if (rx_ready && !rdy_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_t   <= $time;
    end
    rdy_prev <= rx_ready;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  // Reference model: parity judged on the total count of ones on the wire.
  function automatic logic good_pb(input logic [7:0] d, input int pm);
    return (pm == 2) ? ($countones(d) % 2 == 1) : ($countones(d) % 2 == 0);
  endfunction
  function automatic logic m_perr(input logic [7:0] d, input int pm, input logic pb);
    int ones;
    if (pm != 1 && pm != 2) return 1'b0;
    ones = $countones(d) + int'(pb);
    return (pm == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction
  function automatic logic m_ferr(input logic s0, input logic s1, input int ns);
    return !s0 || (ns == 2 && !s1);
  endfunction

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (bit_clk) @(negedge clk);
  endtask
  task automatic idle(input int nbits);
    uart_rx = 1'b1;
    repeat (nbits * bit_clk) @(negedge clk);
  endtask
  task automatic set_div(input int div);
    cfg_clk_div = 16'(div);
    bit_clk = ((div == 0) ? 1 : div) * 16;
    uart_rx = 1'b1;
    repeat (120) @(negedge clk);
  endtask
  task automatic pop();
    @(negedge clk) rx_req = 1'b1;
    @(negedge clk) rx_req = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] d, input int pm, input logic pb,
                            input logic s0, input logic s1, input int ns);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pm == 1 || pm == 2) drive_bit(pb);
    stop_t = $time;
    drive_bit(s0);
    if (ns == 2) drive_bit(s1);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", rx_ready); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {parity_err, frame_err, overrun}); end
    rst = 1'b0;
    repeat (100) @(negedge clk);
  endtask

  task automatic test_8e1();
    int r0;
    longint lat;
    logic pb;
    r0 = rise_cnt;
    cfg_parity = 2'd2; cfg_stop_bits = 2'd0;
    pb = good_pb(8'hA5, 2);
    send_frame(8'hA5, 2, pb, 1'b1, 1'b1, 1);
    repeat (4) @(negedge clk);
    lat = (rise_t - stop_t) / 10;
    checks++; if (rise_cnt != r0 + 1) begin errors++; $display("FAIL 8e1_commits got %0d exp %0d", rise_cnt - r0, 1); end
    checks++; if (lat < 432 || lat > 500) begin errors++; $display("FAIL 8e1_latency got %0d exp 432..500", lat); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL 8e1_data got %h exp a5", rx_data); end
    checks++; if (parity_err !== m_perr(8'hA5, 2, pb)) begin errors++; $display("FAIL 8e1_perr got %b exp %b", parity_err, m_perr(8'hA5, 2, pb)); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL 8e1_ferr got %b exp 0", frame_err); end
    pop();
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL 8e1_pop_ready got %b exp 0", rx_ready); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL 8e1_pop_hold got %h exp a5", rx_data); end
  endtask

  task automatic test_parity();
    cfg_parity = 2'd2;
    send_frame(8'h03, 2, 1'b1, 1'b1, 1'b1, 1);
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h03) begin errors++; $display("FAIL par_even_data got %h exp 03", rx_data); end
    checks++; if (parity_err !== m_perr(8'h03, 2, 1'b1)) begin errors++; $display("FAIL par_even_err got %b exp %b", parity_err, m_perr(8'h03, 2, 1'b1)); end
    pop(); idle(1);
    cfg_parity = 2'd1;
    send_frame(8'h03, 1, 1'b1, 1'b1, 1'b1, 1);
    repeat (4) @(negedge clk);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL par_odd_ready got %b exp 1", rx_ready); end
    checks++; if (parity_err !== m_perr(8'h03, 1, 1'b1)) begin errors++; $display("FAIL par_odd_err got %b exp %b", parity_err, m_perr(8'h03, 1, 1'b1)); end
    pop(); idle(1);
  endtask

  task automatic test_glitch();
    int r0;
    r0 = rise_cnt;
    cfg_parity = 2'd0;
    uart_rx = 1'b0;
    repeat (22) @(negedge clk);
    idle(3);
    checks++; if (rise_cnt != r0 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL glitch_commit got %0d exp 0", rise_cnt - r0); end
    send_frame(8'h3C, 0, 1'b0, 1'b1, 1'b1, 1);
    repeat (4) @(negedge clk);
    checks++; if (rx_ready !== 1'b1 || rx_data !== 8'h3C) begin
      errors++; $display("FAIL glitch_next got %b/%h exp 1/3c", rx_ready, rx_data); end
    pop(); idle(1);
  endtask

  task automatic test_break();
    int r0;
    r0 = rise_cnt;
    send_frame(8'h5A, 0, 1'b0, 1'b0, 1'b1, 1);
    uart_rx = 1'b0;
    repeat (20 * bit_clk) @(negedge clk);
    checks++; if (rise_cnt != r0 + 1) begin errors++; $display("FAIL break_commits got %0d exp 1", rise_cnt - r0); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL break_data got %h exp 5a", rx_data); end
    checks++; if (frame_err !== m_ferr(1'b0, 1'b1, 1)) begin errors++; $display("FAIL break_ferr got %b exp 1", frame_err); end
    pop(); idle(2);
    send_frame(8'h96, 0, 1'b0, 1'b1, 1'b1, 1);
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h96 || frame_err !== 1'b0) begin
      errors++; $display("FAIL break_after got %h/%b exp 96/0", rx_data, frame_err); end
    pop(); idle(1);
  endtask

  task automatic test_overrun();
    int o0;
    bit seen;
    o0 = ovr_cnt;
    send_frame(8'h11, 0, 1'b0, 1'b1, 1'b1, 1); idle(1);
    send_frame(8'h22, 0, 1'b0, 1'b1, 1'b1, 1); idle(1);
    checks++; if (ovr_cnt != o0 + 1) begin errors++; $display("FAIL ovr_pulse got %0d exp 1", ovr_cnt - o0); end
    checks++; if (rx_data !== 8'h11 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL ovr_hold got %h/%b exp 11/1", rx_data, rx_ready); end
    seen = 1'b0;
    fork
      send_frame(8'h22, 0, 1'b0, 1'b1, 1'b1, 1);
      begin
        for (int i = 0; i < 14 * bit_clk && !seen; i++) begin
          @(negedge clk);
          if (dut.commit_q) begin
            seen = 1'b1;
            rx_req = 1'b1;
            @(negedge clk) rx_req = 1'b0;
          end
        end
      end
    join
    if (!seen) begin checks++; errors++; $display("FAIL ovr_align_timeout got 0 exp 1"); end
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h22 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL ovr_align got %h/%b exp 22/1", rx_data, rx_ready); end
    checks++; if (ovr_cnt != o0 + 1) begin errors++; $display("FAIL ovr_align_pulse got %0d exp 1", ovr_cnt - o0); end
  endtask

  task automatic test_reset_mid();
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", rx_ready); end
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    repeat (bit_clk / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({rx_ready, parity_err, frame_err, overrun} !== 4'b0000 || rx_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_async got %b/%h exp 0000/00", {rx_ready, parity_err, frame_err, overrun}, rx_data); end
    @(negedge clk); @(negedge clk) rst = 1'b0;
    idle(3);
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_partial got %b exp 0", rx_ready); end
    cfg_stop_bits = 2'd1;
    send_frame(8'h7E, 0, 1'b0, 1'b1, 1'b1, 2);
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h7E || {parity_err, frame_err} !== 2'b00 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_next got %h/%b exp 7e/00", rx_data, {parity_err, frame_err}); end
    pop(); idle(1);
  endtask

  task automatic test_random();
    int divs[5] = '{0, 1, 3, 4, 6};
    for (int n = 0; n < 8; n++) begin
      int pm, ns, r0;
      logic [7:0] d;
      logic pb, s0, s1;
      set_div(divs[$urandom_range(0, 4)]);
      pm = $urandom_range(0, 3);
      ns = $urandom_range(1, 2);
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      cfg_parity    = 2'(pm);
      cfg_stop_bits = (ns == 1) ? 2'd0 : 2'($urandom_range(1, 3));
      r0 = rise_cnt;
      send_frame(d, pm, pb, s0, s1, ns);
      idle(1);
      checks++; if (rise_cnt != r0 + 1) begin errors++; $display("FAIL rnd%0d_commit got %0d exp 1", n, rise_cnt - r0); end
      checks++; if (rx_data !== d) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", n, rx_data, d); end
      checks++; if (parity_err !== m_perr(d, pm, pb)) begin errors++; $display("FAIL rnd%0d_perr got %b exp %b", n, parity_err, m_perr(d, pm, pb)); end
      checks++; if (frame_err !== m_ferr(s0, s1, ns)) begin errors++; $display("FAIL rnd%0d_ferr got %b exp %b", n, frame_err, m_ferr(s0, s1, ns)); end
      pop(); idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_8e1();
    set_div(4);
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
